// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, aligns/extends load data, feeds WB and decode bypass.
// Zero added latency when ready (loads wait for data_ok); valid/allowin handshake, data_ok held in a buffer under WB backpressure.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 76,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [38:0]                ms_to_ds_bus
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
  logic                       buf_valid;
  logic [31:0]                buf_data;

  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic [1:0]  addr_lo;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign ld_type      = ms_bus[75:73];
  assign res_from_mem = ms_bus[72];
  assign addr_lo      = ms_bus[71:70];
  assign gr_we        = ms_bus[69];
  assign dest         = ms_bus[68:64];
  assign alu_result   = ms_bus[63:32];
  assign pc           = ms_bus[31:0];

  logic ms_ready_go;
  assign ms_ready_go    = !res_from_mem || data_sram_data_ok || buf_valid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  logic [31:0] load_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_res;
  logic [31:0] final_result;

  always_comb begin
    load_word = buf_valid ? buf_data : data_sram_rdata;
    ld_byte   = load_word[{addr_lo, 3'b000} +: 8];
    ld_half   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (ld_type)
      3'b001:  load_res = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_res = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_res = {24'b0, ld_byte};
      3'b110:  load_res = {16'b0, ld_half};
      default: load_res = load_word;
    endcase
    final_result = res_from_mem ? load_res : alu_result;
  end

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = {ms_valid && res_from_mem && !ms_ready_go,
                         ms_valid && gr_we && ms_ready_go,
                         dest, final_result};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) ms_bus <= es_to_ms_bus;
    end
  end

  // Catch the one-cycle data_ok pulse only when WB cannot take the result right now.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      buf_valid <= 1'b0;
    end else if (ms_valid && res_from_mem && data_sram_data_ok && !buf_valid && !ws_allowin) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected WB bus words plus point checks of stall/bypass/reset outputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_ds_bus;

  int n_checks = 0;
  int n_fail   = 0;
  logic [69:0] sb_q[$];

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_allowin       (ms_allowin),
    .ws_allowin       (ws_allowin),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ms_to_ds_bus     (ms_to_ds_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk(input logic [2:0] lt, input logic rfm, input logic [1:0] lo,
                                     input logic we, input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {lt, rfm, lo, we, dst, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge, any WB handshake pops the scoreboard; returns 1ns after the posedge.
  task automatic tick();
    logic [69:0] exp;
    @(negedge clk);
    if (ms_to_ws_valid && ws_allowin) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wb_output", ms_to_ws_bus, 70'h0);
        chk("unexpected_wb_valid", {69'b0, ms_to_ws_valid}, 70'h0);
      end else begin
        exp = sb_q.pop_front();
        chk("wb_bus", ms_to_ws_bus, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Load issued, stalls one cycle, then data_ok arrives with WB ready.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [31:0] rd, input logic [31:0] expf, input logic [31:0] pc);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(lt, 1'b1, lo, 1'b1, 5'd7, 32'h1c00_0100, pc);
    sb_q.push_back({1'b1, 5'd7, expf, pc});
    tick();
    es_to_ms_valid = 1'b0;
    chk({tag, "_pending"}, {69'b0, ms_to_ds_bus[38]}, 70'd1);
    data_sram_rdata   = rd;
    data_sram_data_ok = 1'b1;
    #1;
    chk({tag, "_fwd"}, {32'b0, ms_to_ds_bus[37:0]}, {32'b0, 1'b1, 5'd7, expf});
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #1;
    chk("rst_valid",   {69'b0, ms_to_ws_valid}, 70'd0);
    chk("rst_bus",     ms_to_ws_bus, 70'd0);
    chk("rst_ds_bus",  {31'b0, ms_to_ds_bus}, 70'd0);
    chk("rst_allowin", {69'b0, ms_allowin}, 70'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // ALU op passes straight through the next cycle.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'b000, 1'b0, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000);
    sb_q.push_back({1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
    tick();
    es_to_ms_valid = 1'b0;
    chk("alu_valid", {69'b0, ms_to_ws_valid}, 70'd1);
    chk("alu_fwd", {31'b0, ms_to_ds_bus}, {31'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678});
    tick();
    chk("alu_drained", {69'b0, ms_to_ws_valid}, 70'd0);

    do_load("ldb",   3'b001, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 32'h1c00_0004);
    do_load("ldbu",  3'b101, 2'd2, 32'h0080_0000, 32'h0000_0080, 32'h1c00_0008);
    do_load("ldh",   3'b010, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001, 32'h1c00_000c);
    do_load("ldhu",  3'b110, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF, 32'h1c00_0010);
    do_load("ldb3",  3'b001, 2'd3, 32'h7F00_00FF, 32'h0000_007F, 32'h1c00_0014);
    do_load("ldhu2", 3'b110, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF, 32'h1c00_0018);
    do_load("ldw",   3'b000, 2'd0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h1c00_001c);
    do_load("ldrsv", 3'b011, 2'd1, 32'h8765_4321, 32'h8765_4321, 32'h1c00_0020);

    // Load stall: three cycles without data_ok.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'b000, 1'b1, 2'd0, 1'b1, 5'd9, 32'h0, 32'h1c00_0030);
    sb_q.push_back({1'b1, 5'd9, 32'h1122_3344, 32'h1c00_0030});
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid",   {69'b0, ms_to_ws_valid}, 70'd0);
      chk("stall_pending", {69'b0, ms_to_ds_bus[38]}, 70'd1);
      chk("stall_allowin", {69'b0, ms_allowin}, 70'd0);
      tick();
    end
    data_sram_rdata   = 32'h1122_3344;
    data_sram_data_ok = 1'b1;
    #1;
    chk("stall_release_valid", {69'b0, ms_to_ws_valid}, 70'd1);
    tick();
    data_sram_data_ok = 1'b0;

    // WB backpressure: data captured in the hold buffer while rdata moves on.
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'b000, 1'b1, 2'd0, 1'b1, 5'd3, 32'h0, 32'h1c00_0040);
    sb_q.push_back({1'b1, 5'd3, 32'hCAFE_BABE, 32'h1c00_0040});
    tick();
    es_to_ms_valid    = 1'b0;
    data_sram_rdata   = 32'hCAFE_BABE;
    data_sram_data_ok = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("bp_hold_valid",  {69'b0, ms_to_ws_valid}, 70'd1);
    chk("bp_hold_data",   {38'b0, ms_to_ws_bus[63:32]}, {38'b0, 32'hCAFE_BABE});
    chk("bp_hold_allowin", {69'b0, ms_allowin}, 70'd0);
    tick();
    ws_allowin = 1'b1;
    tick();
    chk("bp_drained", {69'b0, ms_to_ws_valid}, 70'd0);
    // A fresh load must stall again, proving the hold buffer was released.
    do_load("after_bp", 3'b000, 2'd0, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h1c00_0044);

    // Async reset mid-stall, then a stale data_ok.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'b001, 1'b1, 2'd1, 1'b1, 5'd4, 32'h0, 32'h1c00_0050);
    tick();
    es_to_ms_valid = 1'b0;
    chk("pre_rst_pending", {69'b0, ms_to_ds_bus[38]}, 70'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid",   {69'b0, ms_to_ws_valid}, 70'd0);
    chk("mid_rst_bus",     ms_to_ws_bus, 70'd0);
    chk("mid_rst_ds_bus",  {31'b0, ms_to_ds_bus}, 70'd0);
    chk("mid_rst_allowin", {69'b0, ms_allowin}, 70'd1);
    tick();
    resetn            = 1'b1;
    ws_allowin        = 1'b0;
    data_sram_rdata   = 32'h5555_AAAA;
    data_sram_data_ok = 1'b1;
    #1;
    chk("stale_ok_valid", {69'b0, ms_to_ws_valid}, 70'd0);
    tick();
    data_sram_data_ok = 1'b0;
    ws_allowin        = 1'b1;
    #1;
    chk("stale_ok_bus", {69'b0, ms_to_ws_valid}, 70'd0);
    do_load("after_rst", 3'b101, 2'd1, 32'h0000_9900, 32'h0000_0099, 32'h1c00_0060);

    tick();
    chk("sb_empty", {38'b0, 32'(sb_q.size())}, 70'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
